pp_pkt_builder: RTL and testbench

- Host-side packet builder. It is the write end of the 48-bit RAH packet FIFO that pp_decoder reads.
- It accepts a command (slave select, cfg flag, byte length) and a byte stream, then emits one header word followed by packed payload words into the FIFO.
- It honours FIFO full backpressure, so the testbench and host bridge can drive periplex peripherals without hand-building packets.

---
 rtl/pp_pkt_builder.sv | 161 ++++++++++++++++
 tb/tb_pp_pkt_builder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_pkt_builder.sv
// pp_pkt_builder
// Write end of the 48-bit RAH packet FIFO read by pp_decoder. Takes one
// command (slave select, cfg flag, byte length) plus a byte stream and emits
// one header word followed by ceil(len/6) MSB-first packed payload words.
//
// Header word : [47:41] slv_sel, [40] cfg, [39:33] len, [32:0] zero.
// Payload word: byte k of the word sits at [47-8k -: 8]; unused low bytes 0.
//
// Ports
//   pp_clk        clock, rising edge
//   rst           synchronous reset, active-high
//   cmd_valid     command present
//   cmd_ready     command accepted on cmd_valid & cmd_ready (IDLE only)
//   cmd_slv_sel   target slave id
//   cmd_cfg       1 = config write, 0 = data write
//   cmd_len       payload length in bytes (0 is rejected with len_err)
//   byte_valid    payload byte present
//   byte_ready    byte accepted on byte_valid & byte_ready (COLLECT only)
//   byte_data     payload byte
//   fifo_full     downstream FIFO full
//   fifo_wr_en    write strobe, one word per asserted cycle
//   fifo_wr_data  word being written, 0 whenever fifo_wr_en is low
//   busy          packet in progress
//   len_err       one-cycle pulse after a zero-length command is accepted
module pp_pkt_builder #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int SEL_WIDTH        = 7,
  parameter int LEN_WIDTH        = 7,
  parameter int BYTE_WIDTH       = 8
) (
  input  logic                        pp_clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [SEL_WIDTH-1:0]        cmd_slv_sel,
  input  logic                        cmd_cfg,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  input  logic [BYTE_WIDTH-1:0]       byte_data,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [RAH_PACKET_WIDTH-1:0] fifo_wr_data,
  output logic                        busy,
  output logic                        len_err
);

  localparam int WORD_BYTES = RAH_PACKET_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH  = $clog2(WORD_BYTES + 1);
  localparam int RSVD_WIDTH = RAH_PACKET_WIDTH - SEL_WIDTH - 1 - LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR, COLLECT, PUSH} state_t;

  state_t                      state_reg;
  logic [SEL_WIDTH-1:0]        slv_sel_reg;
  logic                        cfg_reg;
  logic [LEN_WIDTH-1:0]        len_reg;
  logic [LEN_WIDTH-1:0]        remaining_reg;
  logic [IDX_WIDTH-1:0]        idx_reg;
  logic [RAH_PACKET_WIDTH-1:0] shift_reg;
  logic                        len_err_reg;

  logic                        byte_fire;
  logic                        wr_fire;
  logic [WORD_BYTES-1:0]       lane_we;
  logic [RAH_PACKET_WIDTH-1:0] shift_next;
  logic [RAH_PACKET_WIDTH-1:0] header_word;
  logic [IDX_WIDTH-1:0]        idx_inc;
  logic [LEN_WIDTH-1:0]        remaining_dec;

  // Handshake outputs decode straight from the state register, so they carry
  // no combinational path from any input.
  assign cmd_ready  = (state_reg == IDLE);
  assign byte_ready = (state_reg == COLLECT);
  assign busy       = (state_reg != IDLE);
  assign len_err    = len_err_reg;

  assign byte_fire = byte_valid && (state_reg == COLLECT);

  // The write strobe follows fifo_full in the same cycle so a word is never
  // pushed into a full FIFO; data is forced to 0 whenever nothing is written.
  assign wr_fire      = ((state_reg == HDR) || (state_reg == PUSH)) && !fifo_full;
  assign fifo_wr_en   = wr_fire;
  assign fifo_wr_data = !wr_fire ? '0 :
                        (state_reg == HDR) ? header_word : shift_reg;

  assign header_word = {slv_sel_reg, cfg_reg, len_reg, {RSVD_WIDTH{1'b0}}};

  assign idx_inc       = idx_reg + IDX_WIDTH'(1);
  // Only decremented on an accepted byte, which COLLECT guarantees only while
  // bytes remain; the guard keeps the count from ever wrapping.
  assign remaining_dec = (remaining_reg == '0) ? '0 : remaining_reg - LEN_WIDTH'(1);

  // One byte lane per word position: lane gi loads when the incoming byte is
  // the gi-th of the current word, MSB-first.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      localparam int LANE_HI = RAH_PACKET_WIDTH - 1 - BYTE_WIDTH * gi;
      assign lane_we[gi] = byte_fire && (idx_reg == IDX_WIDTH'(gi));
      assign shift_next[LANE_HI -: BYTE_WIDTH] =
        lane_we[gi] ? byte_data : shift_reg[LANE_HI -: BYTE_WIDTH];
    end
  endgenerate

  always_ff @(posedge pp_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      slv_sel_reg   <= '0;
      cfg_reg       <= 1'b0;
      len_reg       <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      len_err_reg   <= 1'b0;
    end else begin
      len_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              // Accepted and dropped: report it, write nothing.
              len_err_reg <= 1'b1;
            end else begin
              slv_sel_reg   <= cmd_slv_sel;
              cfg_reg       <= cmd_cfg;
              len_reg       <= cmd_len;
              remaining_reg <= cmd_len;
              idx_reg       <= '0;
              shift_reg     <= '0;
              state_reg     <= HDR;
            end
          end
        end
        HDR: begin
          if (!fifo_full) begin
            state_reg <= COLLECT;
          end
        end
        COLLECT: begin
          if (byte_fire) begin
            shift_reg     <= shift_next;
            idx_reg       <= idx_inc;
            remaining_reg <= remaining_dec;
            if ((idx_inc == IDX_WIDTH'(WORD_BYTES)) || (remaining_dec == '0)) begin
              state_reg <= PUSH;
            end
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            idx_reg   <= '0;
            shift_reg <= '0;
            state_reg <= (remaining_reg == '0) ? IDLE : COLLECT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pkt_builder.sv
// Testbench for pp_pkt_builder: directed packets with hand-computed words.
// Expected words are queued by the stimulus; a negedge monitor pops and
// compares every FIFO write and watches the write rules each cycle.
module tb_pp_pkt_builder;

  logic        pp_clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_slv_sel;
  logic        cmd_cfg;
  logic [6:0]  cmd_len;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [47:0] fifo_wr_data;
  logic        busy;
  logic        len_err;

  pp_pkt_builder dut (
    .pp_clk       (pp_clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_slv_sel  (cmd_slv_sel),
    .cmd_cfg      (cmd_cfg),
    .cmd_len      (cmd_len),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .len_err      (len_err)
  );

  always #5 pp_clk = ~pp_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          writes   = 0;
  logic [47:0] exp_q[$];
  logic [7:0]  bbuf[0:127];

  task automatic cmp(input string name, input logic [47:0] act,
                     input logic [47:0] exp, input bit verbose = 1'b1);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge pp_clk) begin
    if (rst === 1'b0) begin
      if (fifo_full === 1'b1)
        cmp("no_write_while_full", {47'b0, fifo_wr_en}, 48'd0, 1'b0);
      if (fifo_wr_en === 1'b1) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %h required no write (t=%0t)",
                   fifo_wr_data, $time);
        end else begin
          cmp("fifo_word", fifo_wr_data, exp_q.pop_front());
        end
      end else begin
        cmp("idle_data_zero", fifo_wr_data, 48'd0, 1'b0);
      end
    end
  end

  task automatic send_cmd(input logic [6:0] sel, input logic cfg, input logic [6:0] len);
    bit acc = 1'b0;
    @(posedge pp_clk); #1;
    cmd_valid = 1'b1; cmd_slv_sel = sel; cmd_cfg = cfg; cmd_len = len;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge pp_clk); acc = cmd_ready;
      @(posedge pp_clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) cmp("cmd_accept_timeout", 48'd0, 48'd1);
    if (len != 0 && !fifo_full) cmp("hdr_latency", {47'b0, fifo_wr_en}, 48'd1);
  endtask

  task automatic send_bytes(input int n, input int stall_idx);
    bit acc;
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1; byte_data = bbuf[i]; acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge pp_clk); acc = byte_ready;
        @(posedge pp_clk); #1;
      end
      if (!acc) cmp("byte_accept_timeout", 48'd0, 48'd1);
      if (i == stall_idx) begin
        // Now in PUSH: hold the FIFO full for 5 cycles.
        byte_valid = 1'b0; fifo_full = 1'b1; #1;
        cmp("push_stall_no_write", {47'b0, fifo_wr_en}, 48'd0);
        repeat (5) @(posedge pp_clk);
        #1; cmp("push_stall_busy", {47'b0, busy}, 48'd1);
        fifo_full = 1'b0;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int w0, input int exp_writes);
    bit idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(negedge pp_clk); idle = !busy;
    end
    cmp("busy_drop", {47'b0, busy}, 48'd0);
    cmp("write_count", 48'(writes - w0), 48'(exp_writes));
    cmp("queue_drained", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_cmd_ready"},  {47'b0, cmd_ready},  48'd1);
    cmp({tag, "_byte_ready"}, {47'b0, byte_ready}, 48'd0);
    cmp({tag, "_wr_en"},      {47'b0, fifo_wr_en}, 48'd0);
    cmp({tag, "_wr_data"},    fifo_wr_data,        48'd0);
    cmp({tag, "_busy"},       {47'b0, busy},       48'd0);
    cmp({tag, "_len_err"},    {47'b0, len_err},    48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_slv_sel = '0; cmd_cfg = 1'b0; cmd_len = '0;
    byte_valid = 1'b0; byte_data = '0; fifo_full = 1'b0;
    repeat (3) @(posedge pp_clk);
    #1; check_reset_outputs("reset");
    rst = 1'b0;

    // len=4: header + one partial word
    bbuf[0] = 8'h11; bbuf[1] = 8'h22; bbuf[2] = 8'h33; bbuf[3] = 8'h44;
    exp_q.push_back(48'h0B0800000000); exp_q.push_back(48'h112233440000);
    w0 = writes; send_cmd(7'h05, 1'b1, 7'd4); send_bytes(4, -1); wait_idle(w0, 2);

    // len=6: exactly one full word
    for (int i = 0; i < 6; i++) bbuf[i] = 8'hA1 + 8'(i);
    exp_q.push_back(48'hFE0C00000000); exp_q.push_back(48'hA1A2A3A4A5A6);
    w0 = writes; send_cmd(7'h7F, 1'b0, 7'd6); send_bytes(6, -1); wait_idle(w0, 2);

    // len=7: full word then a one-byte word
    for (int i = 0; i < 7; i++) bbuf[i] = 8'h01 + 8'(i);
    exp_q.push_back(48'h020E00000000); exp_q.push_back(48'h010203040506);
    exp_q.push_back(48'h070000000000);
    w0 = writes; send_cmd(7'h01, 1'b0, 7'd7); send_bytes(7, -1); wait_idle(w0, 3);

    // len=13 unstalled, then with stalls on HDR and on the second PUSH
    for (int i = 0; i < 13; i++) bbuf[i] = 8'h01 + 8'(i);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(48'h241A00000000); exp_q.push_back(48'h010203040506);
      exp_q.push_back(48'h0708090A0B0C); exp_q.push_back(48'h0D0000000000);
      w0 = writes;
      if (r == 1) begin
        @(posedge pp_clk); #1; fifo_full = 1'b1;
      end
      send_cmd(7'h12, 1'b0, 7'd13);
      if (r == 1) begin
        cmp("hdr_stall_no_write", {47'b0, fifo_wr_en}, 48'd0);
        repeat (5) @(posedge pp_clk);
        #1; cmp("hdr_stall_no_progress", 48'(writes - w0), 48'd0);
        fifo_full = 1'b0;
      end
      send_bytes(13, (r == 1) ? 11 : -1);
      wait_idle(w0, 4);
    end

    // len=0: accepted, len_err pulse, nothing written
    w0 = writes;
    send_cmd(7'h09, 1'b1, 7'd0);
    cmp("len0_len_err_pulse", {47'b0, len_err},    48'd1);
    cmp("len0_cmd_ready",     {47'b0, cmd_ready},  48'd1);
    cmp("len0_busy",          {47'b0, busy},       48'd0);
    cmp("len0_wr_en",         {47'b0, fifo_wr_en}, 48'd0);
    @(posedge pp_clk); #1;
    cmp("len0_len_err_clear", {47'b0, len_err},    48'd0);
    repeat (3) @(posedge pp_clk);
    #1; cmp("len0_no_writes", 48'(writes - w0), 48'd0);

    // Reset mid-packet after 3 of 10 bytes, then a len=1 packet
    for (int i = 0; i < 3; i++) bbuf[i] = 8'h5A + 8'(i);
    exp_q.push_back(48'h071400000000);
    w0 = writes; send_cmd(7'h03, 1'b1, 7'd10); send_bytes(3, -1);
    byte_valid = 1'b1; byte_data = 8'h77;
    rst = 1'b1;
    @(posedge pp_clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (10) @(posedge pp_clk);
    #1; byte_valid = 1'b0;
    cmp("midrst_only_header", 48'(writes - w0), 48'd1);
    cmp("midrst_queue_empty", 48'(exp_q.size()), 48'd0);

    bbuf[0] = 8'hFF;
    exp_q.push_back(48'h000200000000); exp_q.push_back(48'hFF0000000000);
    w0 = writes; send_cmd(7'h00, 1'b0, 7'd1); send_bytes(1, -1); wait_idle(w0, 2);

    repeat (3) @(posedge pp_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
